// File: rtl/vend_credit_fsm_if.sv
// Coin/cancel inputs and credit/vend/change outputs of the credit controller.
// master = coin acceptor side, slave = vend_credit_fsm.
interface vend_credit_fsm_if;
  logic       coin_n;
  logic       coin_d;
  logic       coin_q;
  logic       cancel;
  logic [3:0] credit;
  logic       vend;
  logic [3:0] chg_code;
  logic       chg_valid;
  logic       coin_rej;

  modport master (
    output coin_n, coin_d, coin_q, cancel,
    input  credit, vend, chg_code, chg_valid, coin_rej
  );

  modport slave (
    input  coin_n, coin_d, coin_q, cancel,
    output credit, vend, chg_code, chg_valid, coin_rej
  );
endinterface

// File: rtl/vend_credit_fsm.sv
// Vending credit controller: coins in nickels, vend, change/refund hold.
// Optional macro VEND_CANCEL_EN enables cancel/refund.
module vend_credit_fsm #(
  parameter int PRICE       = 7,
  parameter int VEND_CYCLES = 4,
  parameter int HOLD_CYCLES = 8
) (
  input logic        clk,
  input logic        reset_n,
  vend_credit_fsm_if.slave bus
);

  typedef enum logic [2:0] {
    IDLE,
    COLLECT,
    VEND,
    CHANGE,
    REFUND
  } state_t;

  localparam int MAXC =
    (VEND_CYCLES > HOLD_CYCLES) ? VEND_CYCLES : HOLD_CYCLES;
  localparam int CW = $clog2(MAXC + 1);
  localparam logic [3:0] PRICE4 = 4'(PRICE);
  localparam logic [CW-1:0] VEND_LAST = CW'(VEND_CYCLES - 1);
  localparam logic [CW-1:0] HOLD_LAST = CW'(HOLD_CYCLES - 1);

  state_t        state_q, state_d;
  logic [3:0]    credit_q, credit_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic          vend_q, vend_d;
  logic [3:0]    code_q, code_d;
  logic          valid_q, valid_d;
  logic          rej_q, rej_d;

  logic       any_coin;
  logic       multi;
  logic [3:0] coin_val;
  logic [3:0] sum;
  logic       cancel_ok;

`ifdef VEND_CANCEL_EN
  assign cancel_ok = bus.cancel;
`else
  logic unused_cancel;
  assign unused_cancel = bus.cancel;
  assign cancel_ok = 1'b0;
`endif

  assign any_coin = bus.coin_n | bus.coin_d | bus.coin_q;
  assign multi = (bus.coin_q & (bus.coin_d | bus.coin_n))
               | (bus.coin_d & bus.coin_n);

  // Highest-value coin wins; the rest are returned.
  always_comb begin
    coin_val = 4'd0;
    if (bus.coin_q)
      coin_val = 4'd5;
    else if (bus.coin_d)
      coin_val = 4'd2;
    else if (bus.coin_n)
      coin_val = 4'd1;
  end

  assign sum = credit_q + coin_val;

  // Next-state and next registered outputs.
  always_comb begin
    state_d  = state_q;
    credit_d = credit_q;
    cnt_d    = cnt_q;
    vend_d   = vend_q;
    code_d   = code_q;
    valid_d  = valid_q;
    rej_d    = any_coin;
    unique case (state_q)
      IDLE: begin
        rej_d = multi;
        if (any_coin) begin
          credit_d = sum;
          cnt_d    = '0;
          if (sum >= PRICE4) begin
            state_d = VEND;
            vend_d  = 1'b1;
          end else begin
            state_d = COLLECT;
          end
        end
      end
      COLLECT: begin
        rej_d    = multi;
        credit_d = sum;
        cnt_d    = '0;
        if (sum >= PRICE4) begin
          state_d = VEND;
          vend_d  = 1'b1;
        end else if (cancel_ok) begin
          state_d = REFUND;
          valid_d = 1'b1;
          code_d  = sum;
        end
      end
      VEND: begin
        if (cnt_q == VEND_LAST) begin
          state_d = CHANGE;
          vend_d  = 1'b0;
          valid_d = 1'b1;
          code_d  = credit_q - PRICE4;
          cnt_d   = '0;
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end
      CHANGE, REFUND: begin
        if (cnt_q == HOLD_LAST) begin
          state_d  = IDLE;
          credit_d = 4'd0;
          valid_d  = 1'b0;
          code_d   = 4'd0;
          cnt_d    = '0;
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  // State and output registers with synchronous reset.
  always_ff @(posedge clk) begin
    if (!reset_n) begin
      state_q  <= IDLE;
      credit_q <= 4'd0;
      cnt_q    <= '0;
      vend_q   <= 1'b0;
      code_q   <= 4'd0;
      valid_q  <= 1'b0;
      rej_q    <= 1'b0;
    end else begin
      state_q  <= state_d;
      credit_q <= credit_d;
      cnt_q    <= cnt_d;
      vend_q   <= vend_d;
      code_q   <= code_d;
      valid_q  <= valid_d;
      rej_q    <= rej_d;
    end
  end

  assign bus.credit    = credit_q;
  assign bus.vend      = vend_q;
  assign bus.chg_code  = code_q;
  assign bus.chg_valid = valid_q;
  assign bus.coin_rej  = rej_q;

endmodule
